// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: a registered FIFO between fetch and decode.
// Supports flush on branch redirect and a sticky flag for pushes lost to a flush.
module instr_fetch_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_instr,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push;
  logic             pop;

  // Handshake status is derived only from the registered occupancy.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? mem[rd_ptr] : '0;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (in_valid && in_ready) begin
        overrun <= 1'b1;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= in_instr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: stimulus queues expected words,
// a negedge monitor checks every word the buffer hands to decode.
module tb_instr_fetch_buffer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_instr;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic             out_ready;
  logic             flush;
  logic [2:0]       count;
  logic             overrun;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  instr_fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_ready(out_ready), .flush(flush), .count(count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [WIDTH-1:0] w);
    exp_q.push_back(w);
  endtask

  // Monitor: a pop happens at the coming edge when out_valid && out_ready && !flush.
  always @(negedge clk) begin
    if (reset === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got 0x%08h expected none at %0t", out_instr, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_instr !== e) begin
          errors++;
          $display("FAIL word_order: got 0x%08h expected 0x%08h at %0t", out_instr, e, $time);
        end
      end
    end else if (out_valid === 1'b0 && reset === 1'b0) begin
      chk("idle_out_instr_zero", out_instr, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int mcnt;
    int next_w;
    int cyc;
    logic ordy;

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;

    // Fill then drain.
    in_valid = 1'b1;
    in_instr = 32'h11; sb_push(32'h11); step();
    in_instr = 32'h22; sb_push(32'h22); step();
    in_instr = 32'h33; sb_push(32'h33); step();
    in_instr = 32'h44; sb_push(32'h44); step();
    in_valid = 1'b0;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_head", out_instr, 32'h11);
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // First-word latency.
    in_valid = 1'b1; in_instr = 32'hA5A5A5A5; sb_push(32'hA5A5A5A5);
    #1;
    chk("lat_before_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("lat_after_valid", 32'(out_valid), 32'd1);
    chk("lat_after_instr", out_instr, 32'hA5A5A5A5);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("lat_drained", 32'(count), 32'd0);

    // Full with push attempt and pop.
    in_valid = 1'b1;
    in_instr = 32'h61; sb_push(32'h61); step();
    in_instr = 32'h62; sb_push(32'h62); step();
    in_instr = 32'h63; sb_push(32'h63); step();
    in_instr = 32'h64; sb_push(32'h64); step();
    in_instr = 32'h55; out_ready = 1'b1;
    #1;
    chk("full_no_bypass_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_in_ready", 32'(in_ready), 32'd1);
    sb_push(32'h55);
    step();
    chk("push_pop_count", 32'(count), 32'd3);
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b0;
    chk("full_drain_count", 32'(count), 32'd0);

    // Wrap stream 1..10 with out_ready toggling, against a simple occupancy model.
    mcnt = 0; next_w = 1; cyc = 0;
    while (next_w <= 10 && cyc < 100) begin
      logic acc, pp;
      ordy = (cyc % 2 == 0);
      in_valid = 1'b1; in_instr = 32'(next_w); out_ready = ordy;
      acc = (mcnt != DEPTH);
      pp  = (mcnt != 0) && ordy;
      #1;
      chk("wrap_in_ready", 32'(in_ready), 32'(acc));
      if (acc) begin
        sb_push(32'(next_w));
        next_w++;
      end
      step();
      mcnt = mcnt + (acc ? 1 : 0) - (pp ? 1 : 0);
      chk("wrap_count", 32'(count), 32'(mcnt));
      cyc++;
    end
    chk("wrap_all_pushed", 32'(next_w), 32'd11);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    out_ready = 1'b0;
    chk("wrap_drain_count", 32'(count), 32'd0);
    chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flush with concurrent push and pop.
    in_valid = 1'b1;
    in_instr = 32'h31; sb_push(32'h31); step();
    in_instr = 32'h32; sb_push(32'h32); step();
    in_instr = 32'h33; sb_push(32'h33); step();
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; in_instr = 32'h77; out_ready = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_instr", out_instr, 32'h0);
    chk("flush_overrun", 32'(overrun), 32'd1);
    step(); step();
    chk("flush_no_77", 32'(out_valid), 32'd0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("overrun_sticky", 32'(overrun), 32'd1);
    out_ready = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Reset mid-stream.
    in_valid = 1'b1;
    in_instr = 32'h81; step();
    in_instr = 32'h82; step();
    in_valid = 1'b0;
    chk("mid_count", 32'(count), 32'd2);
    reset = 1'b1;
    #1;
    chk("hold_in_ready", 32'(in_ready), 32'd1);
    step();
    reset = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_instr", out_instr, 32'h0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_instr = 32'h99; sb_push(32'h99); step();
    in_valid = 1'b0;
    chk("post_rst_head", out_instr, 32'h99);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("post_rst_count", 32'(count), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
